// File: rtl/idelay_tap_line.sv
// idelay_tap_line: 32-tap programmable input delay line.
// The pad (IDATAIN) or fabric (DATAIN) source feeds a chain of buffer
// pairs. A 32:1 mux picks one tap, indexed by either the fixed
// IDELAY_VALUE or a 5-bit tap counter. The counter can be stepped,
// loaded directly, or loaded through a pipeline register.
// Each continuous-assign stage corresponds to one buffer cell. In
// zero-delay simulation every stage is a plain pass-through.
module idelay_tap_line #(
  parameter string CINVCTRL_SEL          = "FALSE",
  parameter string DELAY_SRC             = "IDATAIN",
  parameter string HIGH_PERFORMANCE_MODE = "FALSE",
  parameter string IDELAY_TYPE           = "FIXED",
  parameter int    IDELAY_VALUE          = 0,
  parameter logic  IS_C_INVERTED         = 1'b0,
  parameter logic  IS_DATAIN_INVERTED    = 1'b0,
  parameter logic  IS_IDATAIN_INVERTED   = 1'b0,
  parameter string PIPE_SEL              = "FALSE",
  parameter real   REFCLK_FREQUENCY      = 200.0,
  parameter string SIGNAL_PATTERN        = "DATA"
) (
  input  logic       C,
  input  logic       REGRST,
  input  logic       CE,
  input  logic       INC,
  input  logic       LD,
  input  logic       LDPIPEEN,
  input  logic       CINVCTRL,
  input  logic [4:0] CNTVALUEIN,
  input  logic       DATAIN,
  input  logic       IDATAIN,
  output logic       DATAOUT,
  output logic [4:0] CNTVALUEOUT
);

  localparam bit IS_VARIABLE  = (IDELAY_TYPE == "VARIABLE");
  localparam bit IS_LOADABLE  = (IDELAY_TYPE == "VAR_LOAD") || (IDELAY_TYPE == "VAR_LOAD_PIPE");
  // Any unrecognised type behaves as FIXED: the counter never moves.
  localparam bit IS_FIXED     = !(IS_VARIABLE || IS_LOADABLE);
  localparam bit USE_DATAIN   = (DELAY_SRC == "DATAIN");
  localparam bit DYN_CLK_INV  = (CINVCTRL_SEL == "TRUE");
  localparam bit LOAD_PIPE    = (PIPE_SEL == "TRUE");
  localparam logic [4:0] INIT_TAP = 5'(IDELAY_VALUE);

  // These parameters are accepted for compatibility only and change nothing.
  localparam bit unused_cfg = (HIGH_PERFORMANCE_MODE == "") || (SIGNAL_PATTERN == "") ||
                              (REFCLK_FREQUENCY < 0.0);

  // Input buffer stage: one buffer per input pin.
  logic       c_b, regrst_b, ce_b, inc_b, ld_b, ldpipeen_b, cinvctrl_b;
  logic       datain_b, idatain_b;
  logic [4:0] cntvaluein_b;
  assign c_b          = C;
  assign regrst_b     = REGRST;
  assign ce_b         = CE;
  assign inc_b        = INC;
  assign ld_b         = LD;
  assign ldpipeen_b   = LDPIPEEN;
  assign cinvctrl_b   = CINVCTRL;
  assign cntvaluein_b = CNTVALUEIN;
  assign datain_b     = DATAIN;
  assign idatain_b    = IDATAIN;

  // Clock: static inversion, optional dynamic inversion, then one clock buffer.
  logic clk_int, clk_buf;
  assign clk_int = c_b ^ IS_C_INVERTED ^ (DYN_CLK_INV & cinvctrl_b);
  assign clk_buf = clk_int;

  // Source select with per-source static inversion.
  logic src;
  assign src = USE_DATAIN ? (datain_b ^ IS_DATAIN_INVERTED) : (idatain_b ^ IS_IDATAIN_INVERTED);

  // Delay chain. Tap 0 is one buffer after the source, and each later tap
  // adds two series buffers. Each stage reads its predecessor's node
  // rather than the collected tap vector, so the chain stays acyclic.
  logic [31:0] taps;
  for (genvar n = 0; n < 32; n++) begin : g_tap
    logic node;
    if (n == 0) begin : g_head
      assign node = src;
    end else begin : g_link
      logic half;
      assign half = g_tap[n-1].node;
      assign node = half;
    end
    assign taps[n] = node;
  end

  logic [4:0] pipe;
  logic [4:0] cnt;
  logic [4:0] cnt_next;
  logic [4:0] load_val;
  logic [4:0] eff_tap;

  assign load_val = LOAD_PIPE ? pipe : cntvaluein_b;
  assign eff_tap  = IS_FIXED ? INIT_TAP : cnt;

  // Output mux feeds the output driver; the tap value goes out bit-buffered.
  assign DATAOUT     = taps[eff_tap];
  assign CNTVALUEOUT = eff_tap;

  // Next tap: load beats step, step wraps modulo 32, FIXED never moves.
  always_comb begin
    cnt_next = cnt;
    if (IS_FIXED) begin
      cnt_next = cnt;
    end else if (ld_b) begin
      cnt_next = IS_VARIABLE ? INIT_TAP : load_val;
    end else if (ce_b && inc_b) begin
      cnt_next = cnt + 5'd1;
    end else if (ce_b) begin
      cnt_next = cnt - 5'd1;
    end else begin
      cnt_next = cnt;
    end
  end

  // Tap counter register; reset restores the configured initial tap.
  always_ff @(posedge clk_buf or posedge regrst_b) begin
    if (regrst_b) begin
      cnt <= INIT_TAP;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Pipeline register holds a staged load value. A load at the same edge
  // still sees the old content.
  always_ff @(posedge clk_buf or posedge regrst_b) begin
    if (regrst_b) begin
      pipe <= 5'd0;
    end else if (ldpipeen_b) begin
      pipe <= cntvaluein_b;
    end else begin
      pipe <= pipe;
    end
  end

endmodule

// File: tb/tb_idelay_tap_line.sv
// Self-checking bench for idelay_tap_line. Six instances with different
// configurations share one stimulus stream. A behavioural model tracks
// each instance's tap and pipeline value and is compared on every cycle.
// Directed checks with literal expectations pin the model down.
module tb_idelay_tap_line;

  logic       c = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0, inc = 1'b0, ld = 1'b0, ldp = 1'b0, cinv = 1'b0;
  logic       cinv_on = 1'b1;
  logic [4:0] cin = 5'd0;
  logic       datain = 1'b0, idatain = 1'b0;

  logic [4:0] cnt_out [6];
  logic       dout    [6];

  int checks = 0;
  int errors = 0;

  // Per-instance configuration. Type: 0 FIXED, 1 VARIABLE, 2 VAR_LOAD, 3 VAR_LOAD_PIPE.
  int typ_cfg  [6] = '{0, 1, 2, 3, 3, 1};
  int iv_cfg   [6] = '{7, 30, 4, 4, 9, 0};
  bit psel_cfg [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  int m_cnt  [6];
  int m_pipe [6];

  always #5 c = ~c;

  idelay_tap_line #(.IDELAY_TYPE("FIXED"), .IDELAY_VALUE(7)) d0 (
    .C(c), .REGRST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CINVCTRL(cinv),
    .CNTVALUEIN(cin), .DATAIN(datain), .IDATAIN(idatain), .DATAOUT(dout[0]), .CNTVALUEOUT(cnt_out[0]));
  idelay_tap_line #(.IDELAY_TYPE("VARIABLE"), .IDELAY_VALUE(30)) d1 (
    .C(c), .REGRST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CINVCTRL(cinv),
    .CNTVALUEIN(cin), .DATAIN(datain), .IDATAIN(idatain), .DATAOUT(dout[1]), .CNTVALUEOUT(cnt_out[1]));
  idelay_tap_line #(.IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(4)) d2 (
    .C(c), .REGRST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CINVCTRL(cinv),
    .CNTVALUEIN(cin), .DATAIN(datain), .IDATAIN(idatain), .DATAOUT(dout[2]), .CNTVALUEOUT(cnt_out[2]));
  idelay_tap_line #(.IDELAY_TYPE("VAR_LOAD_PIPE"), .IDELAY_VALUE(4), .PIPE_SEL("TRUE")) d3 (
    .C(c), .REGRST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CINVCTRL(cinv),
    .CNTVALUEIN(cin), .DATAIN(datain), .IDATAIN(idatain), .DATAOUT(dout[3]), .CNTVALUEOUT(cnt_out[3]));
  idelay_tap_line #(.IDELAY_TYPE("VAR_LOAD_PIPE"), .IDELAY_VALUE(9), .PIPE_SEL("FALSE")) d4 (
    .C(c), .REGRST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CINVCTRL(cinv),
    .CNTVALUEIN(cin), .DATAIN(datain), .IDATAIN(idatain), .DATAOUT(dout[4]), .CNTVALUEOUT(cnt_out[4]));
  idelay_tap_line #(.IDELAY_TYPE("VARIABLE"), .IDELAY_VALUE(0), .DELAY_SRC("DATAIN"),
                    .IS_DATAIN_INVERTED(1'b1), .CINVCTRL_SEL("TRUE")) d5 (
    .C(c), .REGRST(rst), .CE(ce), .INC(inc), .LD(ld), .LDPIPEEN(ldp), .CINVCTRL(cinv_on),
    .CNTVALUEIN(cin), .DATAIN(datain), .IDATAIN(idatain), .DATAOUT(dout[5]), .CNTVALUEOUT(cnt_out[5]));

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_cnt[k]  = iv_cfg[k];
      m_pipe[k] = 0;
    end
  endtask

  // One active clock edge for instance k, straight from the tap rules.
  task automatic model_edge(input int k);
    int old_pipe;
    if (rst) return;
    old_pipe = m_pipe[k];
    if (ldp) m_pipe[k] = int'(cin);
    if (typ_cfg[k] == 0) return;
    if (ld)
      m_cnt[k] = (typ_cfg[k] == 1) ? iv_cfg[k] : (psel_cfg[k] ? old_pipe : int'(cin));
    else if (ce)
      m_cnt[k] = (m_cnt[k] + (inc ? 1 : 31)) % 32;
  endtask

  always @(posedge rst) model_reset();

  // Instances 0..4 clock on rising C; instance 5 sees an inverted clock.
  always @(posedge c) for (int k = 0; k < 5; k++) model_edge(k);
  always @(negedge c) model_edge(5);

  // Compare every instance against the model once per cycle.
  always @(posedge c) begin
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cnt_d%0d", k), int'(cnt_out[k]), m_cnt[k]);
      chk($sformatf("dout_d%0d", k), int'(dout[k]), (k == 5) ? int'(!datain) : int'(idatain));
    end
  end

  task automatic tick();
    @(posedge c);
    #2;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge c);
    #2;
    rst = 1'b0;
    chk("rst_d0", int'(cnt_out[0]), 7);
    chk("rst_d1", int'(cnt_out[1]), 30);
    chk("rst_d2", int'(cnt_out[2]), 4);
    chk("rst_d4", int'(cnt_out[4]), 9);
    chk("rst_d5", int'(cnt_out[5]), 0);

    // Increment through the wrap point, then decrement back through it.
    ce = 1'b1; inc = 1'b1;
    tick(); chk("inc1", int'(cnt_out[1]), 31);
    tick(); chk("inc2", int'(cnt_out[1]), 0);
    tick(); chk("inc3", int'(cnt_out[1]), 1);
    chk("fixed_hold", int'(cnt_out[0]), 7);
    inc = 1'b0;
    tick(); chk("dec1", int'(cnt_out[1]), 0);
    tick(); chk("dec2", int'(cnt_out[1]), 31);
    ld = 1'b1; ce = 1'b0;
    tick(); chk("var_ld", int'(cnt_out[1]), 30);

    // Load beats step.
    cin = 5'd5; ld = 1'b1; ce = 1'b1; inc = 1'b1;
    tick(); chk("ld_wins", int'(cnt_out[2]), 5);

    // Two-step load through the pipeline register.
    ld = 1'b0; ce = 1'b0; cin = 5'd12; ldp = 1'b1;
    tick();
    cin = 5'd3; ldp = 1'b0; ld = 1'b1;
    tick(); chk("pipe_ld", int'(cnt_out[3]), 12); chk("nopipe_ld", int'(cnt_out[4]), 3);

    // LD and LDPIPEEN together: the load sees the old pipe content.
    cin = 5'd20; ld = 1'b1; ldp = 1'b1;
    tick(); chk("same_edge_old", int'(cnt_out[3]), 12);
    ldp = 1'b0;
    tick(); chk("same_edge_new", int'(cnt_out[3]), 20);

    // Reset pulse between edges after moving to 9.
    cin = 5'd9; ld = 1'b1;
    tick(); chk("moved_9", int'(cnt_out[2]), 9);
    ld = 1'b0;
    rst = 1'b1;
    #1 chk("async_rst", int'(cnt_out[2]), 4);
    #1 rst = 1'b0;
    cin = 5'd20; ld = 1'b1;
    tick(); chk("pipe_cleared", int'(cnt_out[3]), 0);

    // Source selection and inversion.
    ld = 1'b0; datain = 1'b1; idatain = 1'b1;
    #1 chk("datain_inv1", int'(dout[5]), 0); chk("idatain_d0", int'(dout[0]), 1);
    datain = 1'b0;
    #1 chk("datain_inv0", int'(dout[5]), 1);

    // Reset held across edges overrides every control.
    ld = 1'b1; ce = 1'b1; ldp = 1'b1; inc = 1'b1; cin = 5'd17;
    rst = 1'b1;
    tick();
    chk("rst_hold_d1", int'(cnt_out[1]), 30);
    chk("rst_hold_d3", int'(cnt_out[3]), 4);
    chk("rst_hold_d5", int'(cnt_out[5]), 0);
    rst = 1'b0; ld = 1'b0; ldp = 1'b0;
    tick();
    chk("first_edge", int'(cnt_out[1]), 31);
    chk("fall_edge1", int'(cnt_out[5]), 1);
    #2 chk("no_step_before_fall", int'(cnt_out[5]), 1);
    #2 chk("step_on_fall", int'(cnt_out[5]), 2);
    ce = 1'b0;
    tick();

    // Randomised phase.
    repeat (400) begin
      tick();
      ce      = 1'($urandom);
      inc     = 1'($urandom);
      ld      = ($urandom_range(0, 7) == 0);
      ldp     = ($urandom_range(0, 3) == 0);
      cin     = 5'($urandom);
      cinv    = 1'($urandom);
      datain  = 1'($urandom);
      idatain = 1'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idelay_tap_line.md
# idelay_tap_line

Programmable input delay line: a 32-tap chain of standard-cell buffers selects a delayed copy of the pad data (`IDATAIN`) or the fabric data (`DATAIN`), with a 5-bit tap counter. The tap counter can be fixed, stepped up or down, or loaded, optionally through a pipeline register. It sits between the I/O pad and the input capture flops on the data-receive path. Delay is built only from `BUF_X1`, `BUF_X4` and `CLKBUF_X2` cells. Functional simulation treats those cells as zero-delay pass-throughs.

## Interface
Parameters:
- `CINVCTRL_SEL`, default "FALSE": "TRUE" lets `CINVCTRL` invert the clock dynamically.
- `DELAY_SRC`, default "IDATAIN": "IDATAIN" or "DATAIN". Any other value selects `IDATAIN`.
- `HIGH_PERFORMANCE_MODE`, default "FALSE": accepted, no functional effect.
- `IDELAY_TYPE`, default "FIXED": "FIXED", "VARIABLE", "VAR_LOAD" or "VAR_LOAD_PIPE".
- `IDELAY_VALUE`, default 0: initial and fixed tap, 0..31.
- `IS_C_INVERTED`, default 1'b0: static clock inversion.
- `IS_DATAIN_INVERTED`, default 1'b0: static inversion of `DATAIN`.
- `IS_IDATAIN_INVERTED`, default 1'b0: static inversion of `IDATAIN`.
- `PIPE_SEL`, default "FALSE": "TRUE" makes LD load from the pipeline register.
- `REFCLK_FREQUENCY`, default 200.0: accepted, no functional effect.
- `SIGNAL_PATTERN`, default "DATA": accepted, no functional effect.

Ports:
- `C`, in, 1: the single clock, rising edge, after inversion options.
- `REGRST`, in, 1: reset, asynchronous and active-high.
- `CE`, in, 1: count step enable.
- `INC`, in, 1: step direction; 1 = increment, 0 = decrement.
- `LD`, in, 1: load the tap counter.
- `LDPIPEEN`, in, 1: load the pipeline register from `CNTVALUEIN`.
- `CINVCTRL`, in, 1: dynamic clock invert.
- `CNTVALUEIN`, in, 5: tap value to load.
- `DATAIN`, in, 1: fabric data source.
- `IDATAIN`, in, 1: pad data source.
- `DATAOUT`, out, 1: delayed data.
- `CNTVALUEOUT`, out, 5: current tap.

## Operation
Cell structure:
- Every input passes through one `BUF_X1`.
- The internal clock is `C ^ IS_C_INVERTED`.
- If `CINVCTRL_SEL`="TRUE", the clock is further inverted while `CINVCTRL`=1.
- The clock then drives one `CLKBUF_X2`, which clocks all registers.
- Data source is chosen by `DELAY_SRC`, XOR'd with its `IS_*_INVERTED` bit.

Delay chain:
- tap[0] = source through one `BUF_X1`.
- tap[n] = tap[n-1] through two series `BUF_X1`, for n = 1..31.
- A 32:1 mux indexed by the effective tap feeds one `BUF_X4`, which drives `DATAOUT`.
- Effective tap is `IDELAY_VALUE` when `IDELAY_TYPE`="FIXED", else the tap counter.

`CNTVALUEOUT`:
- Equals the effective tap.
- Each bit passes through one `BUF_X1`.

Pipeline register (`pipe`, 5 bits):
- On a clock edge, if `LDPIPEEN` = 1: `pipe` <= `CNTVALUEIN`.

Load value:
- `pipe` when `PIPE_SEL`="TRUE", else `CNTVALUEIN` (combinational).

Tap counter update, each clock edge, non-FIXED types only:
1. If `LD`: load `IDELAY_VALUE` when type is VARIABLE, else the load value (VAR_LOAD, VAR_LOAD_PIPE).
2. Else if `CE` and `INC`: add 1; 31 wraps to 0.
3. Else if `CE` and not `INC`: subtract 1; 0 wraps to 31.
4. Else: hold.

`LD` has priority over `CE`. `INC` is ignored when `CE`=0.

FIXED type:
- The counter never changes.
- `CE`, `INC`, `LD`, `LDPIPEEN` and `CNTVALUEIN` have no effect on the outputs.

Reset (`REGRST`=1), asynchronous:
- `pipe` = 0.
- Tap counter = `IDELAY_VALUE`.
- `CNTVALUEOUT` = `IDELAY_VALUE`.
- `DATAOUT` = tap[`IDELAY_VALUE`] of the source.
- Reset overrides `LD`, `CE` and `LDPIPEEN` for as long as it is asserted.
- Power-up state is the same as after reset.

## Timing
- Counter and `pipe` update one edge after the control inputs are sampled.
- `CNTVALUEOUT` and the tap select change immediately after that edge.
- In zero-delay simulation, `DATAOUT` follows the source combinationally, with no cycle latency.
- Physical delay is roughly 30–35 ps for tap 0, plus roughly 60–70 ps per additional tap.
- Glitches on `DATAOUT` around a tap change are permitted.
- VAR_LOAD_PIPE with `PIPE_SEL`="TRUE" has 2-cycle load latency: `LDPIPEEN` at edge k, then `LD` at edge k+1 or later.
- `LD` and `LDPIPEEN` asserted at the same edge: `LD` takes the old `pipe` value.
- Asserting reset mid-sequence aborts any pending step or load.
- The first edge after reset is released acts normally.

## Test plan
1. FIXED, `IDELAY_VALUE`=7: toggle `CE`/`INC`/`LD` -> `CNTVALUEOUT` stays 7 and `DATAOUT` follows `IDATAIN`.
2. VARIABLE, `IDELAY_VALUE`=30:
   - `CE`=1, `INC`=1 for 3 edges -> 31, 0, 1.
   - `CE`=1, `INC`=0 for 2 edges -> 0, 31.
   - `LD`=1 -> 30.
3. VAR_LOAD, `CNTVALUEIN`=5, `LD`=1 with `CE`=1, `INC`=1 -> 5 (`LD` wins).
4. VAR_LOAD_PIPE with `PIPE_SEL`="TRUE":
   - `CNTVALUEIN`=12 with `LDPIPEEN`=1, then `CNTVALUEIN`=3 with `LD`=1 -> 12.
   - Same sequence with `PIPE_SEL`="FALSE" -> 3.
5. Pulse `REGRST` between clock edges after the counter has moved to 9 (`IDELAY_VALUE`=4) -> `CNTVALUEOUT`=4 immediately, with no clock edge; `pipe` reads 0 via a following `LD` with `PIPE_SEL`="TRUE".
6. Set `DELAY_SRC`="DATAIN", `IS_DATAIN_INVERTED`=1, then `CINVCTRL_SEL`="TRUE" with `CINVCTRL`=1:
   - `DATAOUT` = ~`DATAIN`.
   - The counter steps on falling edges of `C`.
